// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/read/calc/write sequencer for the 8-bit CPU.
// Optional build macro CPU_SEQ_SINGLE_STEP_EN adds a step input and a STEP state.
module cpu_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUS_WIDTH    = 4,
    parameter int OPCODE_WIDTH = 6,
    parameter int PC_WIDTH     = 8,
    parameter int INSTR_WIDTH  = OPCODE_WIDTH + 2 * BUS_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic                    step,
`endif
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata,
    input  logic                    imem_ack,
    output logic [BUS_WIDTH-1:0]    rf_raddr1,
    output logic [BUS_WIDTH-1:0]    rf_raddr2,
    input  logic [DATA_WIDTH-1:0]   rf_rdata1,
    input  logic [DATA_WIDTH-1:0]   rf_rdata2,
    output logic                    rf_we,
    output logic [BUS_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]   rf_wdata,
    output logic                    alu_en,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [DATA_WIDTH-1:0]   alu_value1,
    output logic [DATA_WIDTH-1:0]   alu_value2,
    output logic [BUS_WIDTH-1:0]    alu_addr1,
    output logic [BUS_WIDTH-1:0]    alu_addr2,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic                    alu_calc_done,
    input  logic                    alu_err,
    input  logic                    alu_finish,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    busy,
    output logic                    halted,
    output logic                    fault
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_CALC,
        S_CWAIT,
        S_WRITE,
        S_HALT,
        S_FAULT
`ifdef CPU_SEQ_SINGLE_STEP_EN
        ,
        S_STEP
`endif
    } state_e;

`ifdef CPU_SEQ_SINGLE_STEP_EN
    localparam state_e S_NEXT = S_STEP;
`else
    localparam state_e S_NEXT = S_FETCH;
`endif

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   val1_q, val1_d;
    logic [DATA_WIDTH-1:0]   val2_q, val2_d;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [BUS_WIDTH-1:0]    fld_a1;
    logic [BUS_WIDTH-1:0]    fld_a2;

    assign opcode = instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign fld_a1 = instr_q[2*BUS_WIDTH-1 -: BUS_WIDTH];
    assign fld_a2 = instr_q[BUS_WIDTH-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        unique case (state_q)
            S_IDLE, S_HALT, S_FAULT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (alu_finish) begin
                    state_d = S_HALT;
                end else if (opcode == '0) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                val1_d  = rf_rdata1;
                val2_d  = rf_rdata2;
                state_d = S_CALC;
            end
            // Error wins over done so a faulting result is never written.
            S_CALC, S_CWAIT: begin
                if (alu_err) begin
                    state_d = S_FAULT;
                end else if (alu_calc_done) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_CWAIT;
                end
            end
            S_WRITE: begin
                pc_d    = pc_q + PC_ONE;
                state_d = S_NEXT;
            end
`ifdef CPU_SEQ_SINGLE_STEP_EN
            S_STEP: begin
                if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign rf_raddr1  = fld_a1;
    assign rf_raddr2  = fld_a2;
    assign rf_we      = (state_q == S_WRITE);
    assign rf_waddr   = fld_a1;
    assign rf_wdata   = rf_we ? alu_result : '0;
    assign alu_en     = (state_q == S_CALC);
    assign alu_opcode = opcode;
    assign alu_value1 = val1_q;
    assign alu_value2 = val2_q;
    assign alu_addr1  = fld_a1;
    assign alu_addr2  = fld_a2;
    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    assign busy = !(state_q inside {S_IDLE, S_HALT, S_FAULT, S_STEP});
`else
    assign busy = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: random programs checked against an instruction-level model.
// Follows CPU_SEQ_SINGLE_STEP_EN by pulsing step whenever the core parks.
`timescale 1ns/1ps
module tb_cpu_sequencer;
    localparam int DW = 8;
    localparam int BW = 4;
    localparam int OW = 6;
    localparam int PW = 8;
    localparam int IW = 14;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    localparam int STEP_X = 1;
`else
    localparam int STEP_X = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          step = 1'b0;
    logic          imem_req, imem_ack;
    logic [PW-1:0] imem_addr, pc;
    logic [IW-1:0] imem_rdata;
    logic [BW-1:0] rf_raddr1, rf_raddr2, rf_waddr, alu_addr1, alu_addr2;
    logic [DW-1:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic [DW-1:0] alu_value1, alu_value2, alu_result;
    logic          rf_we, alu_en, alu_calc_done, alu_err, alu_finish;
    logic [OW-1:0] alu_opcode;
    logic          busy, halted, fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start),
`ifdef CPU_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_en(alu_en), .alu_opcode(alu_opcode),
        .alu_value1(alu_value1), .alu_value2(alu_value2),
        .alu_addr1(alu_addr1), .alu_addr2(alu_addr2),
        .alu_result(alu_result), .alu_calc_done(alu_calc_done),
        .alu_err(alu_err), .alu_finish(alu_finish),
        .pc(pc), .busy(busy), .halted(halted), .fault(fault)
    );

    // Instruction memory with a programmable number of wait states.
    logic [IW-1:0] mem [256];
    int imem_wait = 0;
    int wcnt = 0;
    assign imem_rdata = mem[imem_addr];
    assign imem_ack = imem_req && (wcnt == imem_wait);
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // Register file; rf_sync copies the model's registers in.
    logic [DW-1:0] rf [16];
    logic [DW-1:0] rf_m [16];
    logic rf_sync = 1'b0;
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    always @(posedge clk) begin
        if (rf_sync) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_m[i];
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                            input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
        case (op[5:2])
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x ^ y;
            4'd3: return x & y;
            4'd4: return x | y;
            default: return x + y + 8'd1;
        endcase
    endfunction

    // ALU with a registered result and a programmable done latency.
    int alu_lat = 0;
    bit err_mode = 1'b0;
    logic pend;
    int acnt;
    logic [DW-1:0] res_q;
    logic [DW-1:0] op1, op2;
    assign op1 = alu_opcode[0] ? {4'b0, alu_addr1} : alu_value1;
    assign op2 = alu_opcode[1] ? {4'b0, alu_addr2} : alu_value2;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend <= 1'b0;
            acnt <= 0;
            res_q <= '0;
        end else if (alu_en) begin
            res_q <= alu_f(alu_opcode, op1, op2);
            pend <= (alu_lat != 0);
            acnt <= alu_lat - 1;
        end else if (pend) begin
            if (acnt == 0) pend <= 1'b0;
            else acnt <= acnt - 1;
        end
    end
    assign alu_calc_done = (alu_en && alu_lat == 0) || (pend && acnt == 0);
    assign alu_err = alu_calc_done && err_mode;
    assign alu_finish = (alu_opcode == 6'h3F);
    assign alu_result = res_q;

    // Instruction-level reference state.
    logic [PW-1:0] pc_m = '0;

    function automatic logic [DW-1:0] model_res(input logic [IW-1:0] ins);
        logic [DW-1:0] x, y;
        x = ins[8] ? {4'b0, ins[7:4]} : rf_m[ins[7:4]];
        y = ins[9] ? {4'b0, ins[3:0]} : rf_m[ins[3:0]];
        return alu_f(ins[13:8], x, y);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pc_m = '0;
        chk("start_req", imem_req, 1);
        chk("start_addr", imem_addr, 0);
    endtask

    // Runs one instruction from FETCH entry and checks its effects.
    task automatic exec(input int waits, input int lat, input bit emid,
                        input bit serr, output logic [DW-1:0] wd,
                        output int we_off);
        logic [IW-1:0] ins;
        logic [OW-1:0] opc;
        logic [PW-1:0] a0;
        logic [BW-1:0] wa;
        logic [DW-1:0] exp;
        int we_n, en_n, cyc, achg;
        bit prev_req, done;
        imem_wait = waits;
        alu_lat = lat;
        err_mode = serr;
        ins = mem[pc_m];
        opc = ins[13:8];
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, pc_m);
        a0 = imem_addr;
        we_n = 0; en_n = 0; cyc = 0; achg = 0; we_off = -1;
        wd = '0; wa = '0;
        prev_req = 1'b1;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            start = emid && (k == 2);
            @(negedge clk);
            if (imem_req && prev_req && imem_addr !== a0) achg++;
            if (rf_we) begin
                we_n++;
                we_off = k;
                wd = rf_wdata;
                wa = rf_waddr;
            end
            if (alu_en) en_n++;
            if ((imem_req && !prev_req) || halted || fault) begin
                done = 1'b1;
                cyc = k;
            end
            prev_req = imem_req;
            step = !busy && !halted && !fault && !done;
        end
        start = 1'b0;
        step = 1'b0;
        chk("instr_done", done, 1);
        chk("req_stable", achg, 0);
        if (opc == 6'h3F) begin
            chk("halt_flag", halted, 1);
            chk("halt_cyc", cyc, 2 + waits);
            chk("halt_we", we_n, 0);
            chk("halt_en", en_n, 0);
            chk("halt_pc", pc, pc_m);
        end else if (opc == '0) begin
            pc_m = pc_m + 8'd1;
            chk("nop_cyc", cyc, 2 + waits + STEP_X);
            chk("nop_we", we_n, 0);
            chk("nop_pc", pc, pc_m);
        end else if (serr) begin
            chk("err_fault", fault, 1);
            chk("err_cyc", cyc, 4 + waits + lat);
            chk("err_we", we_n, 0);
            chk("err_en", en_n, 1);
            chk("err_pc", pc, pc_m);
        end else begin
            exp = model_res(ins);
            rf_m[ins[7:4]] = exp;
            pc_m = pc_m + 8'd1;
            chk("alu_cyc", cyc, 5 + waits + lat + STEP_X);
            chk("alu_we_n", we_n, 1);
            chk("alu_we_off", we_off, 4 + waits + lat);
            chk("alu_waddr", wa, ins[7:4]);
            chk("alu_wdata", wd, exp);
            chk("alu_en_n", en_n, 1);
            chk("alu_pc", pc, pc_m);
        end
    endtask

    function automatic logic [IW-1:0] rand_instr();
        logic [OW-1:0] o;
        logic [7:0] r;
        if ($urandom_range(0, 4) == 0) return '0;
        o = OW'($urandom_range(1, 62));
        r = 8'($urandom);
        return {o, r};
    endfunction

    initial begin
        logic [DW-1:0] wd;
        int off;
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) rf_m[i] = 8'($urandom);
        rf_m[1] = 8'd5;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {imem_req, imem_addr, rf_raddr1, rf_raddr2,
                           rf_we, rf_waddr, rf_wdata, alu_en}, 0);
        chk("rst_outs_b", {alu_opcode, alu_value1, alu_value2, alu_addr1,
                           alu_addr2, pc}, 0);
        chk("rst_flags", {busy, halted, fault}, 0);
        rstn = 1'b1;
        rf_sync = 1'b1;
        @(negedge clk);
        rf_sync = 1'b0;
        chk("idle_req", imem_req, 0);

        mem[0] = 14'h0213;
        mem[1] = 14'h0C45;
        do_start();
        exec(0, 0, 0, 0, wd, off);
        chk("add_wdata", wd, 8);
        chk("add_off", off, 4);
        exec(3, 0, 0, 0, wd, off);

        for (int n = 0; n < 40; n++) begin
            mem[pc_m] = rand_instr();
            exec($urandom_range(0, 2), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 0, wd, off);
        end

        mem[pc_m] = 14'h3F00;
        exec(1, 0, 0, 0, wd, off);
        repeat (3) begin
            @(negedge clk);
            chk("halt_hold", {halted, busy, rf_we, alu_en}, 4'b1000);
            chk("halt_pc_hold", pc, pc_m);
        end
        mem[0] = 14'h3F00;
        do_start();
        exec(0, 0, 0, 0, wd, off);
        chk("halt0_pc", pc, 0);

        for (int i = 0; i < 256; i++) mem[i] = '0;
        do_start();
        for (int i = 0; i < 256; i++) exec(0, 0, 0, 0, wd, off);
        chk("wrap_pc", pc, 0);

        mem[pc_m] = 14'h0512;
        exec(1, 1, 0, 1, wd, off);
        err_mode = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("fault_hold", {fault, busy, rf_we}, 3'b100);
            chk("fault_pc_hold", pc, pc_m);
        end
        do_start();

        mem[0] = 14'h0C45;
        alu_lat = 2;
        ok = 1'b0;
        for (int k = 0; k < 12 && !ok; k++) begin
            @(negedge clk);
            ok = alu_en;
        end
        chk("calc_reached", ok, 1);
        rstn = 1'b0;
        #1;
        chk("midrst_a", {imem_req, imem_addr, rf_raddr1, rf_raddr2,
                         rf_we, rf_waddr, rf_wdata, alu_en}, 0);
        chk("midrst_b", {alu_opcode, alu_value1, alu_value2, alu_addr1,
                         alu_addr2, pc, busy, halted, fault}, 0);
        @(negedge clk);
        rstn = 1'b1;
        ok = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rf_we || busy || imem_req || alu_en) ok = 1'b1;
        end
        chk("post_rst_idle", ok, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
